dmem_responder: RTL and testbench

Data-memory slave answering the MEM stage's ram_* request interface: ren/wen strobes, raddr/waddr, wdata, and a 64-bit bit-lane write mask.
- Owns a doubleword-organised data array behind a programmable access latency.
- Drives busy_o back to the MEM stage, which gates its strobes with it.
- Holds read data stable until the next accepted read, because the MEM stage samples ram_rdata combinationally.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 64;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        ok;
        logic [60:0] idx;
    } win_t;

    // Doubleword index relative to base plus an in-window flag; addr[2:0] drops out.
    function automatic win_t dmem_win(input logic [63:0] addr, input logic [63:0] base,
                                      input int unsigned depth_log2);
        logic [63:0] off;
        win_t        w;
        off   = addr - base;
        w.ok  = (addr >= base) && ((off >> (depth_log2 + 3)) == 64'd0);
        w.idx = off[63:3];
        return w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: async read, single bit-masked synchronous write port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: one request in flight, fixed per-op latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_ren_i,
    input  logic              ram_wen_i,
    input  logic [63:0]       ram_raddr_i,
    input  logic [63:0]       ram_waddr_i,
    input  logic [DATA_W-1:0] ram_wdata_i,
    input  logic [DATA_W-1:0] ram_wmask_i,
    output logic [DATA_W-1:0] ram_rdata_o,
    output logic              rvalid_o,
    output logic              wdone_o,
    output logic              busy_o,
    output logic              addr_err_o
);

    localparam logic [3:0] RL  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WL  = 4'(WR_LATENCY - 1);
    localparam logic [3:0] RWL = (RD_LATENCY > WR_LATENCY) ? RL : WL;

    state_t            state;
    logic [3:0]        cnt;
    logic              op_rd, op_wr, rd_ok, wr_ok;
    logic [60:0]       ridx_q, widx_q;
    logic [DATA_W-1:0] wdata_q, wmask_q;

    win_t              rwin, wwin;
    logic [3:0]        lat_m1;
    logic              arr_we, same_idx;
    logic [DATA_W-1:0] arr_rdata, rd_word;

    assign rwin = dmem_win(ram_raddr_i, BASE_ADDR, DEPTH_LOG2);
    assign wwin = dmem_win(ram_waddr_i, BASE_ADDR, DEPTH_LOG2);

    always_comb begin
        lat_m1 = WL;
        if (ram_ren_i)
            lat_m1 = ram_wen_i ? RWL : RL;
    end

    // Reset is folded into the enable so a request abandoned in RESP never commits.
    assign arr_we   = rst && (state == RESP) && op_wr && wr_ok;
    assign same_idx = op_wr && wr_ok && (widx_q == ridx_q);
    assign rd_word  = same_idx ? ((arr_rdata & ~wmask_q) | (wdata_q & wmask_q)) : arr_rdata;

    dmem_array #(.AW(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (widx_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .raddr (ridx_q[DEPTH_LOG2-1:0]),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ram_rdata_o <= '0;
            rvalid_o    <= 1'b0;
            wdone_o     <= 1'b0;
            busy_o      <= 1'b0;
            addr_err_o  <= 1'b0;
        end else begin
            rvalid_o   <= 1'b0;
            wdone_o    <= 1'b0;
            addr_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= ram_ren_i | ram_wen_i;
                    if (ram_ren_i | ram_wen_i) begin
                        op_rd   <= ram_ren_i;
                        op_wr   <= ram_wen_i;
                        rd_ok   <= rwin.ok;
                        wr_ok   <= wwin.ok;
                        ridx_q  <= rwin.idx;
                        widx_q  <= wwin.idx;
                        wdata_q <= ram_wdata_i;
                        wmask_q <= ram_wmask_i;
                        cnt     <= lat_m1;
                        state   <= (lat_m1 != 4'd0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    rvalid_o   <= op_rd;
                    wdone_o    <= op_wr;
                    addr_err_o <= (op_rd && !rd_ok) || (op_wr && !wr_ok);
                    if (op_rd)
                        ram_rdata_o <= rd_ok ? rd_word : '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: expected responses queued at issue, checked by a separate monitor.
module tb_dmem_responder;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: RD_LATENCY=2, WR_LATENCY=1
    logic        rst, ren, wen, rvalid, wdone, busy, aerr;
    logic [63:0] raddr, waddr, wdata, wmask, rdata;

    dmem_responder dut (
        .clk(clk), .rst(rst), .ram_ren_i(ren), .ram_wen_i(wen),
        .ram_raddr_i(raddr), .ram_waddr_i(waddr), .ram_wdata_i(wdata), .ram_wmask_i(wmask),
        .ram_rdata_o(rdata), .rvalid_o(rvalid), .wdone_o(wdone), .busy_o(busy), .addr_err_o(aerr)
    );

    // Second instance for reset-mid-write: WR_LATENCY=3
    logic        rst2, ren2, wen2, rvalid2, wdone2, busy2, aerr2;
    logic [63:0] raddr2, waddr2, wdata2, wmask2, rdata2;

    dmem_responder #(.WR_LATENCY(3)) dut2 (
        .clk(clk), .rst(rst2), .ram_ren_i(ren2), .ram_wen_i(wen2),
        .ram_raddr_i(raddr2), .ram_waddr_i(waddr2), .ram_wdata_i(wdata2), .ram_wmask_i(wmask2),
        .ram_rdata_o(rdata2), .rvalid_o(rvalid2), .wdone_o(wdone2), .busy_o(busy2), .addr_err_o(aerr2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        rv, wd, err, dc;
        logic [63:0] rd;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        mon_on = 1'b0;
    logic [63:0] held = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (rvalid || wdone || aerr) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'd0, 64'd1);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("rvalid", 64'(rvalid), 64'(mon_e.rv));
                    chk("wdone", 64'(wdone), 64'(mon_e.wd));
                    chk("addr_err", 64'(aerr), 64'(mon_e.err));
                    if (mon_e.rv && !mon_e.dc)
                        chk("rdata", rdata, mon_e.rd);
                end
            end
            if (rvalid) held <= rdata;
            else        chk("rdata_hold", rdata, held);
        end
    end

    logic        mon2_on = 1'b0;
    int          wd2_cnt = 0, rv2_cnt = 0, wd2_cyc = 0;
    logic [63:0] rd2_last = '0;

    always @(negedge clk) begin
        if (mon2_on) begin
            if (wdone2) begin
                wd2_cnt <= wd2_cnt + 1;
                wd2_cyc <= cyc;
            end
            if (rvalid2) begin
                rv2_cnt  <= rv2_cnt + 1;
                rd2_last <= rdata2;
            end
        end
    end

    // Issue one request on dut, queue its response, and check busy over the whole window.
    task automatic req(input logic r, input logic w, input logic [63:0] ra, input logic [63:0] wa,
                       input logic [63:0] wd, input logic [63:0] wm, input int lat,
                       input logic [63:0] exp_rd, input logic exp_err, input logic dc);
        exp_t e;
        @(negedge clk);
        ren = r; wen = w; raddr = ra; waddr = wa; wdata = wd; wmask = wm;
        e.cyc = cyc + 1 + lat; e.rv = r; e.wd = w; e.err = exp_err; e.dc = dc; e.rd = exp_rd;
        q.push_back(e);
        @(negedge clk);
        ren = 0; wen = 0;
        for (int k = 0; k <= lat; k++) begin
            chk("busy_high", 64'(busy), 64'd1);
            @(negedge clk);
        end
        chk("busy_low", 64'(busy), 64'd0);
    endtask

    localparam logic [63:0] ONES = '1;

    initial begin
        int t;
        rst = 0; ren = 0; wen = 0; raddr = 0; waddr = 0; wdata = 0; wmask = 0;
        rst2 = 0; ren2 = 0; wen2 = 0; raddr2 = 0; waddr2 = 0; wdata2 = 0; wmask2 = 0;
        repeat (2) @(negedge clk);
        rst = 1; rst2 = 1;
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", {61'd0, rvalid, wdone, aerr}, 64'd0);
        mon_on = 1'b1;
        mon2_on = 1'b1;

        // read of uninitialised word 0: timing only
        req(1, 0, 64'h8000_0000, 0, 0, 0, 2, 0, 0, 1);
        // masked write then read-back
        req(0, 1, 0, 64'h8000_0010, 64'h1122334455667788, ONES, 1, 0, 0, 0);
        req(0, 1, 0, 64'h8000_0010, 64'hAA, 64'hFF, 1, 0, 0, 0);
        req(1, 0, 64'h8000_0010, 0, 0, 0, 2, 64'h11223344556677AA, 0, 0);
        // low address bits ignored
        req(1, 0, 64'h8000_0017, 0, 0, 0, 2, 64'h11223344556677AA, 0, 0);
        // combined RW, same index returns merged value
        req(0, 1, 0, 64'h8000_0020, 0, ONES, 1, 0, 0, 0);
        req(1, 1, 64'h8000_0020, 64'h8000_0020, 64'hFFFF, 64'hFFFF, 2, 64'hFFFF, 0, 0);
        // combined RW, different index returns old read word
        req(1, 1, 64'h8000_0010, 64'h8000_0028, 64'h55, ONES, 2, 64'h11223344556677AA, 0, 0);
        req(1, 0, 64'h8000_0028, 0, 0, 0, 2, 64'h55, 0, 0);
        // out-of-window read and write (0x8000_8000 aliases word 0 if not dropped)
        req(1, 0, 64'h7FFF_FFF8, 0, 0, 0, 2, 64'd0, 1, 0);
        req(0, 1, 0, 64'h8000_0000, 64'h0BADF00D0BADF00D, ONES, 1, 0, 0, 0);
        req(0, 1, 0, 64'h8000_8000, ONES, ONES, 1, 0, 1, 0);
        req(1, 0, 64'h8000_0000, 0, 0, 0, 2, 64'h0BADF00D0BADF00D, 0, 0);
        req(1, 0, 64'h8000_7FF8, 0, 0, 0, 2, 64'd0, 0, 1);
        // zero mask leaves word unchanged
        req(0, 1, 0, 64'h8000_0010, ONES, 64'd0, 1, 0, 0, 0);
        req(1, 0, 64'h8000_0010, 0, 0, 0, 2, 64'h11223344556677AA, 0, 0);

        // strobes held while busy: accepted at T and T+3 only
        @(negedge clk);
        ren = 1; raddr = 64'h8000_0020;
        t = cyc + 1;
        q.push_back('{t + 2, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF});
        q.push_back('{t + 5, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF});
        repeat (6) @(negedge clk);
        ren = 0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        // dut2: good write, then a write abandoned by reset
        @(negedge clk);
        wen2 = 1; waddr2 = 64'h8000_0008; wdata2 = 64'h1234; wmask2 = ONES;
        t = cyc + 1;
        @(negedge clk);
        wen2 = 0;
        for (int i = 0; i < 20 && wd2_cnt == 0; i++) @(negedge clk);
        chk("wr3_done", 64'(wd2_cnt), 64'd1);
        chk("wr3_cycle", 64'(wd2_cyc), 64'(t + 3));
        repeat (2) @(negedge clk);
        wen2 = 1; wdata2 = 64'hDEAD;
        @(negedge clk);
        wen2 = 0; rst2 = 0;
        @(negedge clk);
        rst2 = 1;
        chk("midrst_busy", 64'(busy2), 64'd0);
        chk("midrst_rdata", rdata2, 64'd0);
        repeat (6) @(negedge clk);
        chk("midrst_no_wdone", 64'(wd2_cnt), 64'd1);
        ren2 = 1; raddr2 = 64'h8000_0008;
        @(negedge clk);
        ren2 = 0;
        for (int i = 0; i < 20 && rv2_cnt == 0; i++) @(negedge clk);
        chk("midrst_rvalid", 64'(rv2_cnt), 64'd1);
        chk("midrst_readback", rd2_last, 64'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
